muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M multiply/divide unit, instantiated beside the execute-stage ALU.
- Accepts an M-extension op while the instruction sits in execute, and holds the pipeline stalled through the hazard unit until done.
- Delivers the result for one cycle, when execute latches it in place of the ALU output.
- Iterative: 1 bit per cycle, shift-add for multiply, restoring for divide.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  execute holds a valid, non-invalidated M-extension instruction.
- function_in  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_in  in  32  operand A (multiplicand/dividend).
- rs2_data_in  in  32  operand B (multiplier/divisor).
- invalidate  in  1  kill from the hazard unit; aborts any operation.
- busy  out  1  stall request to the hazard unit.
- result_valid  out  1  result is valid this cycle.
- result  out  32  product/quotient/remainder.

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state=IDLE, count=0, internal accumulators=0, result=0, result_valid=0, busy=0.
- busy (combinational) = !invalidate && ((state==IDLE && start) || state==BUSY). It is asserted in the same cycle start first rises, so execute never advances past an M-op.
- IDLE && start && !invalidate, at the edge:
  - latch function_in and operand magnitudes.
  - latch result-sign flags:
    - MULH: sign = a31^b31.
    - MULHSU: sign = a31 (B unsigned).
    - DIV: sign = a31^b31.
    - REM: sign = a31.
    - All unsigned ops: sign = 0.
  - count=0.
  - go to BUSY, except on the fast paths below.
- Fast paths (IDLE go straight to DONE, total 2 cycles):
  - Divisor==0: quotient=0xFFFFFFFF and remainder=rs1 for all four divide ops.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- BUSY: one iteration per cycle, count increments.
  - Multiply: 64-bit product register, add-and-shift on multiplier LSB.
  - Divide: 32-bit remainder plus quotient shift register, trial subtract.
  - At count==31 the final iteration completes, the 2's-complement sign fix-up is applied to the 64-bit product or the quotient/remainder, and the state goes to DONE. count wraps to 0.
- DONE, for exactly one cycle:
  - result_valid=1, busy=0.
  - result = low 32 product bits (MUL), high 32 bits (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
  - start is ignored, because the same instruction is still presented. The next state is always IDLE.
- Latency: start cycle, plus 32 BUSY cycles, plus the DONE cycle, so execute occupancy is 34 cycles (fast path 2). Back-to-back M-ops: the second start is accepted in the IDLE cycle after DONE.
- result holds its last value outside DONE. Consumers qualify it with result_valid.
- invalidate, in any state:
  - busy=0 and result_valid=0 combinationally in that cycle.
  - next state IDLE, count=0.
  - no result is produced; invalidate takes priority over start.
- Async reset mid-operation: immediate return to reset values. A new start after reset release behaves normally.
- function_in and operands are sampled only at acceptance. Changes during BUSY are ignored.

Decomposition:
- params.vh:
  - MULDIV_* funct3 encodings (MULDIV_MUL … MULDIV_REMU).
  - MD_STATE_IDLE/BUSY/DONE.
  - MD_DIV_ZERO_QUOT (all-ones).
- One sub-module, muldiv_datapath: operand/accumulator registers, per-iteration step and sign fix-up, driven by load/step/finish strobes.
- muldiv_sequencer keeps the FSM, counter, fast-path detection and busy/result_valid generation.

Test Plan:
- MUL 7*6 → busy high at cycles 0–32, result_valid at cycle 33, result=0x0000002A; busy low in cycle 33; start still high in cycle 33 does not restart.
- MULH 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each with 34-cycle latency.
- DIVU 7/0 → 0xFFFFFFFF; REM 7/0 → 7. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. Each has result_valid in cycle 1 (2-cycle path).
- invalidate at BUSY count 10 → busy=0 that cycle, no result_valid ever; next MUL 3*5 → 15 after 34 cycles.
- reset_n low at BUSY count 20 → immediate IDLE, all outputs 0; after release, DIVU 9/3 → 3 with normal latency.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_sequencer_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    localparam logic [31:0] MD_DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_OVF_QUOT      = 32'h8000_0000;

    typedef enum logic [1:0] {
        MdStateIdle,
        MdStateBusy,
        MdStateDone
    } md_state_e;

    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_MULHSU) || (f == MULDIV_DIV) ||
               (f == MULDIV_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Operand/accumulator registers: shift-add multiply, restoring divide, sign fix-up.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  logic            fast_i,
    input  logic [2:0]      func_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] fast_result_i,
    output logic [XLEN-1:0] result_o
);

    logic [2:0]      func_q;
    logic            sign_q;
    logic [XLEN-1:0] opnd_q, hi_q, lo_q, result_q;

    logic            a_neg, b_neg, sign_ld;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_nxt, prod_fix;
    logic              div_ge;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, rem_fix, quo_fix;
    logic [XLEN-1:0]   step_hi, step_lo, final_res;

    always_comb begin
        a_neg = op_a_signed(func_i) & a_i[XLEN-1];
        b_neg = op_b_signed(func_i) & b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        unique case (func_i)
            MULDIV_MULH, MULDIV_DIV:  sign_ld = a_neg ^ b_neg;
            MULDIV_MULHSU, MULDIV_REM: sign_ld = a_neg;
            default:                  sign_ld = 1'b0;
        endcase
    end

    // Multiply: hi:lo is the product register, lo initially holds the multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
        prod_nxt  = lo_q[0] ? {mul_sum, lo_q[XLEN-1:1]} : {1'b0, hi_q, lo_q[XLEN-1:1]};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[XLEN];
        rem_nxt   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_nxt   = {lo_q[XLEN-2:0], div_ge};
        step_hi   = func_q[2] ? rem_nxt : prod_nxt[2*XLEN-1:XLEN];
        step_lo   = func_q[2] ? quo_nxt : prod_nxt[XLEN-1:0];
        prod_fix  = sign_q ? -prod_nxt : prod_nxt;
        quo_fix   = sign_q ? -quo_nxt : quo_nxt;
        rem_fix   = sign_q ? -rem_nxt : rem_nxt;
        unique case (func_q)
            MULDIV_MUL:                              final_res = prod_fix[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                 final_res = quo_fix;
            default:                                 final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            func_q   <= MULDIV_MUL;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                func_q <= func_i;
                sign_q <= sign_ld;
                opnd_q <= func_i[2] ? b_mag : a_mag;
                hi_q   <= '0;
                lo_q   <= func_i[2] ? a_mag : b_mag;
            end else if (step_i) begin
                hi_q <= step_hi;
                lo_q <= step_lo;
            end
            if (finish_i) begin
                result_q <= final_res;
            end else if (fast_i) begin
                result_q <= fast_result_i;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, fast paths and stall handshake.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      function_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            invalidate,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    md_state_e        state_q;
    logic [CNT_W-1:0] count_q;

    logic            accept, div_zero, div_ovf, fast_hit;
    logic            load, step, finish, fast;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        div_zero = (rs2_data_in == '0);
        div_ovf  = ((function_in == MULDIV_DIV) || (function_in == MULDIV_REM)) &&
                   (rs1_data_in == MD_OVF_QUOT) && (rs2_data_in == MD_DIV_ZERO_QUOT);
        fast_hit = function_in[2] && (div_zero || div_ovf);
        // funct3[1] selects remainder among the divide ops.
        if (function_in[1]) begin
            fast_result = div_zero ? rs1_data_in : '0;
        end else begin
            fast_result = div_zero ? MD_DIV_ZERO_QUOT : MD_OVF_QUOT;
        end
        accept = (state_q == MdStateIdle) && start && !invalidate;
        load   = accept && !fast_hit;
        fast   = accept && fast_hit;
        step   = (state_q == MdStateBusy) && !invalidate;
        finish = step && (count_q == {CNT_W{1'b1}});
    end

    assign busy = !invalidate &&
                  (((state_q == MdStateIdle) && start) || (state_q == MdStateBusy));
    assign result_valid = !invalidate && (state_q == MdStateDone);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MdStateIdle;
            count_q <= '0;
        end else if (invalidate) begin
            state_q <= MdStateIdle;
            count_q <= '0;
        end else begin
            unique case (state_q)
                MdStateIdle: begin
                    count_q <= '0;
                    if (start) begin
                        state_q <= fast_hit ? MdStateDone : MdStateBusy;
                    end
                end
                MdStateBusy: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == {CNT_W{1'b1}}) begin
                        state_q <= MdStateDone;
                    end
                end
                default: begin
                    state_q <= MdStateIdle;
                end
            endcase
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (load),
        .step_i       (step),
        .finish_i     (finish),
        .fast_i       (fast),
        .func_i       (function_in),
        .a_i          (rs1_data_in),
        .b_i          (rs2_data_in),
        .fast_result_i(fast_result),
        .result_o     (result)
    );

endmodule
